sprite_dma_writer: RTL and testbench

//  Bus-master copy engine that writes a sprite table into the shared 32Kx16 video RAM,
//  the writer counterpart of the tile/sprite renderers that read it.
//  CPU programs SRC/DST/LEN/CTRL registers, then the engine requests the RAM bus.
//  The request is ORed into CPU hold; the engine copies LEN words, one RAM_sync access per cycle.

---
 rtl/sprite_dma_writer.sv | 165 ++++++++++++++++
 tb/tb_sprite_dma_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma_writer.sv
// sprite_dma_writer: bus-master copy engine that writes a sprite table into the
// shared 32Kx16 video RAM. The CPU programs SRC/DST/LEN, then writes CTRL.start.
// The engine raises bus_req (ORed into CPU hold) and copies LEN words through a
// RAM with one-cycle read latency: RD -> RDW -> WR per word, 3 cycles/word.
// Optional build macro: SPRITE_DMA_FILL_EN enables CTRL bit1 = fill, which writes
// the SRC register value to LEN words at DST (1 cycle/word, no reads).
module sprite_dma_writer #(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 16,
  parameter int                LEN_W     = 7,
  parameter logic [ADDR_W-1:0] DST_RESET = 15'h7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [1:0] SEL_SRC  = 2'd0;
  localparam logic [1:0] SEL_DST  = 2'd1;
  localparam logic [1:0] SEL_LEN  = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_reg, dst_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [ADDR_W-1:0] src_cnt, dst_cnt;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic              fill_q;
  logic              done_q;

  logic              cfg_ok;
  logic              ctrl_wr;
  logic              start;
  logic              fill_req;
  logic              unused_cfg_bits;

  // Register writes are only honoured while the engine is idle.
  assign cfg_ok  = cfg_we && (state == S_IDLE);
  assign ctrl_wr = cfg_ok && (cfg_sel == SEL_CTRL);
  assign start   = ctrl_wr && cfg_wdata[0];

`ifdef SPRITE_DMA_FILL_EN
  assign fill_req = cfg_wdata[1];
`else
  assign fill_req = 1'b0;
`endif

  // Upper data bits are not used by every register; fold them into a sink.
  assign unused_cfg_bits = ^cfg_wdata;

  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign bus_req = (state == S_REQ) || (state == S_RD) ||
                   (state == S_RDW) || (state == S_WR);

  // CPU-visible configuration registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_reg <= '0;
      dst_reg <= DST_RESET;
      len_reg <= '0;
    end else if (cfg_ok) begin
      case (cfg_sel)
        SEL_SRC: src_reg <= cfg_wdata[ADDR_W-1:0];
        SEL_DST: dst_reg <= cfg_wdata[ADDR_W-1:0];
        SEL_LEN: len_reg <= cfg_wdata[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Transfer engine: working counters, read-data latch, done flag and FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      src_cnt <= '0;
      dst_cnt <= '0;
      cnt     <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_wr) begin
            // Any CTRL write clears done; a zero-length start completes at once.
            done_q <= start && (len_reg == '0);
            if (start && (len_reg != '0)) begin
              src_cnt <= src_reg;
              dst_cnt <= dst_reg;
              cnt     <= len_reg;
              fill_q  <= fill_req;
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_grant) state <= fill_q ? S_WR : S_RD;
        end
        S_RD: begin
          if (bus_grant) state <= S_RDW;
        end
        S_RDW: begin
          // Read data arrives one cycle after the RD address; no grant needed.
          data_q <= ram_rdata;
          state  <= S_WR;
        end
        S_WR: begin
          if (bus_grant) begin
            if (!fill_q) src_cnt <= src_cnt + ADDR_W'(1);
            dst_cnt <= dst_cnt + ADDR_W'(1);
            cnt     <= cnt - LEN_W'(1);
            if (cnt != LEN_W'(1)) state <= fill_q ? S_WR : S_RD;
            else                  state <= S_FIN;
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM port: driven only while the bus is granted, otherwise parked at zero.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (bus_grant) begin
      case (state)
        S_RD: ram_addr = src_cnt;
        S_WR: begin
          ram_addr  = dst_cnt;
          ram_we    = 1'b1;
          ram_wdata = fill_q ? DATA_W'(src_cnt) : data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma_writer.sv
// tb_sprite_dma_writer: self-checking bench for sprite_dma_writer.
// A 32Kx16 synchronous RAM model is attached to the DUT; a reference memory is
// updated with plain word-by-word ascending copy/fill arithmetic and compared.
module tb_sprite_dma_writer;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 7;
  localparam int MEM    = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [DATA_W-1:0] cfg_wdata;
  logic              busy;
  logic              done;
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  sprite_dma_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DST_RESET(15'h7F00)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_grant(bus_grant),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem     [MEM];
  logic [DATA_W-1:0] ref_mem [MEM];

  // Synchronous RAM, read-before-write, one-cycle read latency. The array is
  // also preloaded from the stimulus block, so it is written with blocking =.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  int we_viol = 0;
  int req_cnt = 0;

  // Bus-protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we && !bus_grant) we_viol++;
    if (bus_req) req_cnt++;
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic poke(input int addr, input logic [DATA_W-1:0] val);
    mem[addr]     = val;
    ref_mem[addr] = val;
  endtask

  // Reference behaviour: ascending word-by-word copy (or fill) modulo RAM size.
  task automatic ref_copy(input int src, input int dst, input int len, input bit fill);
    for (int k = 0; k < len; k++)
      ref_mem[(dst + k) % MEM] = fill ? DATA_W'(src) : ref_mem[(src + k) % MEM];
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Entered and left at posedge+1; the write is taken at the edge in between.
  task automatic cfg_write(input logic [1:0] sel, input logic [DATA_W-1:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  function automatic logic grant_for(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return !(i >= 3 && ((i - 3) % 6) < 3);
      default: return ($urandom_range(3) != 0);
    endcase
  endfunction

  // Program (optionally), start, drive grant per mode, wait for done and check.
  task automatic run_xfer(input string tag, input bit prog, input bit set_dst,
                          input int src, input int dst, input int len,
                          input bit fill, input int gmode);
    bit eff_fill;
    int lat;
    int exp_lat;
`ifdef SPRITE_DMA_FILL_EN
    eff_fill = fill;
`else
    eff_fill = 1'b0;
`endif
    if (prog) begin
      cfg_write(2'd0, DATA_W'(src));
      if (set_dst) cfg_write(2'd1, DATA_W'(dst));
      cfg_write(2'd2, DATA_W'(len));
    end
    ref_copy(src, dst, len, eff_fill);
    cfg_write(2'd3, {14'b0, fill, 1'b1});
    lat = -1;
    for (int i = 0; i < 2000 && lat < 0; i++) begin
      bus_grant = grant_for(gmode, i);
      @(posedge clk); #1;
      if (done) lat = i + 1;
    end
    bus_grant = 1'b0;
    if (gmode == 0)      exp_lat = eff_fill ? len + 2 : 3 * len + 2;
    else if (gmode == 1) exp_lat = 6 * len + 2;
    else                 exp_lat = -1;
    if (exp_lat > 0) check($sformatf("%s_latency", tag), lat, exp_lat);
    else             check($sformatf("%s_done_seen", tag), lat > 0, 1);
    check($sformatf("%s_idle_busy", tag), busy, 0);
    check($sformatf("%s_idle_req", tag), bus_req, 0);
    compare_mem($sformatf("%s_mem", tag));
  endtask

  initial begin
    int r0;
    int lat;
    logic [DATA_W-1:0] orig [5];

    reset     = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    bus_grant = 1'b1;
    for (int i = 0; i < MEM; i++) poke(i, DATA_W'($urandom));
    #22 reset = 1'b1;
    @(posedge clk); #1;

    // Reset state (grant high so a driven address would show up).
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    bus_grant = 1'b0;

    // 4-word copy 0x6000 -> DST reset value 0x7F00, full grant.
    for (int k = 0; k < 4; k++) poke(16'h6000 + k, DATA_W'(k + 1));
    run_xfer("copy4", 1'b1, 1'b0, 16'h6000, 16'h7F00, 4, 1'b0, 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("copy4_word%0d", k), mem[16'h7F00 + k], k + 1);

    // Same copy with grant dropped for 3 cycles in every WR.
    for (int k = 0; k < 4; k++) poke(16'h7F00 + k, 16'h0000);
    run_xfer("copy4_drop", 1'b1, 1'b1, 16'h6000, 16'h7F00, 4, 1'b0, 1);
    for (int k = 0; k < 4; k++)
      check($sformatf("copy4_drop_word%0d", k), mem[16'h7F00 + k], k + 1);
    check("copy4_drop_we_no_grant", we_viol, 0);

    // CTRL write clears done; zero-length start completes next cycle, no request.
    cfg_write(2'd3, 16'h0000);
    check("ctrl_clears_done", done, 0);
    r0 = req_cnt;
    cfg_write(2'd2, 16'h0000);
    cfg_write(2'd3, 16'h0001);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_req", req_cnt - r0, 0);

    // Config writes while busy are ignored.
    cfg_write(2'd0, 16'h1000);
    cfg_write(2'd1, 16'h2000);
    cfg_write(2'd2, 16'h0003);
    ref_copy(16'h1000, 16'h2000, 3, 1'b0);
    bus_grant = 1'b1;
    cfg_write(2'd3, 16'h0001);
    cfg_write(2'd1, 16'h1234);
    cfg_write(2'd2, 16'h0064);
    cfg_write(2'd0, 16'h0005);
    cfg_write(2'd3, 16'h0001);
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    bus_grant = 1'b0;
    check("busy_write_done_seen", lat >= 0, 1);
    compare_mem("busy_write_mem");
    // Restart with the retained registers: must repeat the original copy.
    run_xfer("restart", 1'b0, 1'b0, 16'h1000, 16'h2000, 3, 1'b0, 0);

    // Address wrap on the source side.
    poke(16'h7FFE, 16'hA1A1);
    poke(16'h7FFF, 16'hB2B2);
    poke(16'h0000, 16'hC3C3);
    run_xfer("wrap", 1'b1, 1'b1, 16'h7FFE, 16'h0010, 3, 1'b0, 0);
    check("wrap_w0", mem[16'h0010], 16'hA1A1);
    check("wrap_w1", mem[16'h0011], 16'hB2B2);
    check("wrap_w2", mem[16'h0012], 16'hC3C3);

`ifdef SPRITE_DMA_FILL_EN
    // Fill 64 words with the SRC register value.
    run_xfer("fill64", 1'b1, 1'b1, 16'h00AA, 16'h7F00, 64, 1'b1, 0);
    begin
      int good = 0;
      for (int k = 0; k < 64; k++) if (mem[16'h7F00 + k] === 16'h00AA) good++;
      check("fill64_words", good, 64);
    end
`else
    // Without the fill option CTRL bit1 is ignored: a plain copy runs.
    run_xfer("bit1_ignored", 1'b1, 1'b1, 16'h0100, 16'h0200, 5, 1'b1, 0);
`endif

    // Randomized transfers, full or random grant, random fill bit.
    for (int t = 0; t < 6; t++) begin
      int gm;
      gm = ($urandom_range(1) == 0) ? 0 : 2;
      run_xfer($sformatf("rand%0d", t), 1'b1, 1'b1,
               int'($urandom_range(MEM - 1)), int'($urandom_range(MEM - 1)),
               int'($urandom_range(40, 1)), 1'($urandom_range(1)), gm);
    end

    // Reset mid-copy: LEN=5, abort after word 2 has been written.
    for (int k = 0; k < 5; k++) orig[k] = mem[16'h4000 + k];
    cfg_write(2'd0, 16'h3000);
    cfg_write(2'd1, 16'h4000);
    cfg_write(2'd2, 16'h0005);
    bus_grant = 1'b1;
    cfg_write(2'd3, 16'h0001);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bus_req", bus_req, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_ram_wdata", ram_wdata, 0);
    ref_copy(16'h3000, 16'h4000, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 2; k < 5; k++)
      check($sformatf("abort_word%0d_kept", k + 1), mem[16'h4000 + k], orig[k]);
    compare_mem("abort_mem");
    reset = 1'b1;
    bus_grant = 1'b0;
    @(posedge clk); #1;
    check("final_we_no_grant", we_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
